// File: rtl/instr_pointer_ras_pkg.sv
// Shared definitions for the instruction pointer and its return-address stack:
// operation encodings, default widths and address helpers.
package instr_pointer_ras_pkg;

  localparam int IP_MODE_WIDTH = 3;
  localparam int IP_WORD_SIZE  = 16;

  localparam logic [IP_MODE_WIDTH-1:0] IP_MODE_HOLD       = 3'd0;
  localparam logic [IP_MODE_WIDTH-1:0] IP_MODE_STEP       = 3'd1;
  localparam logic [IP_MODE_WIDTH-1:0] IP_MODE_BRANCH_REL = 3'd2;
  localparam logic [IP_MODE_WIDTH-1:0] IP_MODE_JUMP_ABS   = 3'd3;
  localparam logic [IP_MODE_WIDTH-1:0] IP_MODE_CALL_REL   = 3'd4;
  localparam logic [IP_MODE_WIDTH-1:0] IP_MODE_CALL_ABS   = 3'd5;
  localparam logic [IP_MODE_WIDTH-1:0] IP_MODE_RETURN     = 3'd6;

  function automatic logic ip_is_call(input logic [IP_MODE_WIDTH-1:0] m);
    return (m == IP_MODE_CALL_REL) || (m == IP_MODE_CALL_ABS);
  endfunction

endpackage

// File: rtl/instr_pointer_ras_ras_lifo.sv
// Return-address LIFO: push/pop with occupancy count. Push while full and pop
// while empty are silently ignored; the caller decides whether that is an error.
module ras_lifo
  import instr_pointer_ras_pkg::*;
#(
  parameter int WIDTH = IP_WORD_SIZE,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] top_idx;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign top_idx = count_q - CNT_W'(1);
  assign top_o   = empty_o ? '0 : mem_q[top_idx[IDX_W-1:0]];

  // Push has priority; the top module never requests both in one cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  always_comb begin
    count_d = count_q;
    if (do_push)     count_d = count_q + CNT_W'(1);
    else if (do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Entries carry no reset; a pop only moves the pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[count_q[IDX_W-1:0]] <= din_i;
  end

endmodule

// File: rtl/instr_pointer_ras.sv
// Next instruction pointer with an integrated return-address stack. Every
// operation completes in one cycle; overflow/underflow raise a sticky error.
module instr_pointer_ras
  import instr_pointer_ras_pkg::*;
#(
  parameter int                   WORD_SIZE    = IP_WORD_SIZE,
  parameter int                   STACK_DEPTH  = 8,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               reset_enable,
  input  logic                               update_enable,
  input  logic [IP_MODE_WIDTH-1:0]           mode,
  input  logic [WORD_SIZE-1:0]               adj,
  output logic [WORD_SIZE-1:0]               out,
  output logic [WORD_SIZE-1:0]               ret_addr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               stack_err
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [WORD_SIZE-1:0]        out_q, out_d;
  logic                        err_q, err_d;
  logic                        push, pop;
  logic signed [WORD_SIZE-1:0] pc_s, adj_s;
  logic [WORD_SIZE-1:0]        seq_addr, rel_addr;
  logic [WORD_SIZE-1:0]        top;
  logic [CNT_W-1:0]            count;
  logic                        full, empty;

  // Relative targets are signed adds truncated to the address width, so they
  // wrap in both directions without a flag.
  assign pc_s     = $signed(out_q);
  assign adj_s    = $signed(adj);
  assign seq_addr = out_q + WORD_SIZE'(1);
  assign rel_addr = WORD_SIZE'(pc_s + adj_s);

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (update_enable) begin
      case (mode)
        IP_MODE_STEP:       out_d = seq_addr;
        IP_MODE_BRANCH_REL: out_d = rel_addr;
        IP_MODE_JUMP_ABS:   out_d = adj;
        IP_MODE_CALL_REL, IP_MODE_CALL_ABS: begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            push  = 1'b1;
            out_d = (mode == IP_MODE_CALL_REL) ? rel_addr : adj;
          end
        end
        IP_MODE_RETURN: begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            pop   = 1'b1;
            out_d = top;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_enable) begin
      out_q <= RESET_VECTOR;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  ras_lifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (STACK_DEPTH),
    .CNT_W (CNT_W)
  ) u_ras (
    .clk     (clk),
    .rst     (reset_enable),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (seq_addr),
    .top_o   (top),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out         = out_q;
  assign ret_addr    = top;
  assign depth       = count;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule
